// File: rtl/dcache_wt_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read hits return data combinationally; read misses and all stores go through memory.
module dcache_wt_ctrl #(
  parameter int LINES = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] WriteData_i,
  output logic [31:0] ReadData_o,
  output logic        stall_o,
  output logic        mem_enable_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o
);
  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = 30 - IDX;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_WR_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]      r_state;
  logic [LINES-1:0] r_valid;
  logic [TAGW-1:0] r_tag  [LINES];
  logic [31:0]     r_line [LINES];
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic [31:0]     r_hit_cnt;
  logic [31:0]     r_miss_cnt;
  logic            r_en;
  logic            r_we;

  logic [IDX-1:0]  w_idx;
  logic [IDX-1:0]  w_fill_idx;
  logic [TAGW-1:0] w_tag;
  logic            w_hit;
  logic            w_rd_hit;
  logic            w_rd_miss;
  logic            w_wr;

  assign w_idx      = Address_i[IDX+1:2];
  assign w_tag      = Address_i[31:IDX+2];
  assign w_fill_idx = r_addr[IDX+1:2];

  // Lookup and request classification; a store wins over a simultaneous load.
  always_comb begin
    w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    w_wr      = 1'b0;
    w_rd_hit  = 1'b0;
    w_rd_miss = 1'b0;
    if (r_state == ST_IDLE) begin
      w_wr      = MemWrite_i;
      w_rd_hit  = MemRead_i && !MemWrite_i && w_hit;
      w_rd_miss = MemRead_i && !MemWrite_i && !w_hit;
    end else begin
      w_wr      = 1'b0;
    end
  end

  // Stall and load-data outputs.
  always_comb begin
    stall_o = 1'b0;
    case (r_state)
      ST_IDLE:    stall_o = w_wr || w_rd_miss;
      ST_RD_WAIT: stall_o = 1'b1;
      ST_WR_WAIT: stall_o = 1'b1;
      ST_DONE:    stall_o = 1'b0;
      default:    stall_o = 1'b0;
    endcase
    if (w_rd_hit) begin
      ReadData_o = r_line[w_idx];
    end else begin
      ReadData_o = r_rdata;
    end
  end

  // Control FSM, memory request registers and counters.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_IDLE;
      r_valid    <= '0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_hit_cnt  <= 32'd0;
      r_miss_cnt <= 32'd0;
      r_en       <= 1'b0;
      r_we       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_wr) begin
            r_addr  <= Address_i;
            r_wdata <= WriteData_i;
            r_en    <= 1'b1;
            r_we    <= 1'b1;
            r_state <= ST_WR_WAIT;
          end else if (w_rd_miss) begin
            r_addr     <= Address_i;
            r_en       <= 1'b1;
            r_we       <= 1'b0;
            r_miss_cnt <= r_miss_cnt + 32'd1;
            r_state    <= ST_RD_WAIT;
          end else if (w_rd_hit) begin
            r_rdata   <= r_line[w_idx];
            r_hit_cnt <= r_hit_cnt + 32'd1;
          end
        end
        ST_RD_WAIT: begin
          if (mem_ack_i) begin
            r_en                <= 1'b0;
            r_rdata             <= mem_data_i;
            r_valid[w_fill_idx] <= 1'b1;
            r_state             <= ST_DONE;
          end
        end
        ST_WR_WAIT: begin
          if (mem_ack_i) begin
            r_en    <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: begin
          r_en    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Line storage: store hits update in place, read fills replace tag and data.
  always_ff @(posedge clk_i) begin
    if (w_wr && w_hit) begin
      r_line[w_idx] <= WriteData_i;
    end else if ((r_state == ST_RD_WAIT) && mem_ack_i) begin
      r_line[w_fill_idx] <= mem_data_i;
      r_tag[w_fill_idx]  <= r_addr[31:IDX+2];
    end
  end

  assign mem_enable_o = r_en;
  assign mem_write_o  = r_we;
  assign mem_addr_o   = r_addr;
  assign mem_data_o   = r_wdata;
  assign hit_count_o  = r_hit_cnt;
  assign miss_count_o = r_miss_cnt;
endmodule

// File: tb/tb_dcache_wt_ctrl.sv
// Directed-vector bench for dcache_wt_ctrl (LINES=8) with a latency-programmable memory responder.
module tb_dcache_wt_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        MemRead_i, MemWrite_i, mem_ack_i;
  logic [31:0] Address_i, WriteData_i, mem_data_i;
  logic [31:0] ReadData_o, mem_addr_o, mem_data_o, hit_count_o, miss_count_o;
  logic        stall_o, mem_enable_o, mem_write_o;

  int          vectors = 0;
  int          miscompares = 0;

  int          st, en;
  logic        we_s, ok;
  logic [31:0] rd, ma, md;

  dcache_wt_ctrl #(.LINES(8)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .Address_i(Address_i), .WriteData_i(WriteData_i), .ReadData_o(ReadData_o), .stall_o(stall_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
  );

  always #5 clk_i = ~clk_i;

  // One pipeline request; memory acks in cycle T0+lat. Request is held through DONE, dropped after.
  task automatic xact(input logic rd_i, input logic wr_i, input logic [31:0] addr, input logic [31:0] wd,
                      input int lat, input logic [31:0] mval, output int stalls, output logic [31:0] rdata,
                      output int en_cycles, output logic we, output logic [31:0] maddr,
                      output logic [31:0] mdata, output logic done_ok);
    stalls = 0; en_cycles = 0; we = 1'b0; maddr = 32'd0; mdata = 32'd0; done_ok = 1'b1;
    @(negedge clk_i);
    MemRead_i = rd_i; MemWrite_i = wr_i; Address_i = addr; WriteData_i = wd;
    #1;
    rdata = ReadData_o;
    if (stall_o) begin
      stalls = 1;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk_i);
        if (mem_enable_o) begin
          en_cycles++; we = mem_write_o; maddr = mem_addr_o; mdata = mem_data_o;
        end
        mem_ack_i  = (c == lat);
        mem_data_i = (c == lat) ? mval : 32'h0;
        #1;
        if (stall_o) stalls++;
        if (c == lat) break;
      end
      @(negedge clk_i);
      mem_ack_i = 1'b0; mem_data_i = 32'h0;
      #1;
      done_ok = !stall_o && !mem_enable_o;
      rdata   = ReadData_o;
    end
    @(negedge clk_i);
    MemRead_i = 1'b0; MemWrite_i = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_n_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_ack_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_ack_i = 1'b0;
    Address_i = 32'd0; WriteData_i = 32'd0; mem_data_i = 32'd0;
    #1;
    vectors++; if (mem_enable_o !== 1'b0) begin miscompares++; $display("FAIL reset_en got %b exp 0", mem_enable_o); end
    vectors++; if (ReadData_o !== 32'd0) begin miscompares++; $display("FAIL reset_rdata got %h exp 0", ReadData_o); end
    vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b exp 0", stall_o); end
    vectors++; if (hit_count_o !== 32'd0 || miss_count_o !== 32'd0) begin miscompares++; $display("FAIL reset_cnt got %h/%h exp 0/0", hit_count_o, miss_count_o); end
    vectors++; if (mem_addr_o !== 32'd0 || mem_data_o !== 32'd0 || mem_write_o !== 1'b0) begin miscompares++; $display("FAIL reset_mem got %h/%h/%b exp 0", mem_addr_o, mem_data_o, mem_write_o); end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic test_read_miss_hit();
    xact(1'b1, 1'b0, 32'h40, 32'h0, 3, 32'h1234_5678, st, rd, en, we_s, ma, md, ok);
    vectors++; if (st !== 4) begin miscompares++; $display("FAIL miss_stall got %0d exp 4", st); end
    vectors++; if (en !== 3) begin miscompares++; $display("FAIL miss_en_cycles got %0d exp 3", en); end
    vectors++; if (we_s !== 1'b0 || ma !== 32'h40) begin miscompares++; $display("FAIL miss_req got we=%b addr=%h exp we=0 addr=40", we_s, ma); end
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL miss_done got %b exp 1", ok); end
    vectors++; if (rd !== 32'h1234_5678) begin miscompares++; $display("FAIL miss_data got %h exp 12345678", rd); end
    vectors++; if (miss_count_o !== 32'd1 || hit_count_o !== 32'd0) begin miscompares++; $display("FAIL miss_cnt got %0d/%0d exp 1/0", miss_count_o, hit_count_o); end
    xact(1'b1, 1'b0, 32'h40, 32'h0, 1, 32'hBAD0_BAD0, st, rd, en, we_s, ma, md, ok);
    vectors++; if (st !== 0 || en !== 0) begin miscompares++; $display("FAIL hit_stall got %0d/%0d exp 0/0", st, en); end
    vectors++; if (rd !== 32'h1234_5678) begin miscompares++; $display("FAIL hit_data got %h exp 12345678", rd); end
    vectors++; if (hit_count_o !== 32'd1) begin miscompares++; $display("FAIL hit_cnt got %0d exp 1", hit_count_o); end
  endtask

  task automatic test_write_hit();
    xact(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 2, 32'h0, st, rd, en, we_s, ma, md, ok);
    vectors++; if (st !== 3 || ok !== 1'b1) begin miscompares++; $display("FAIL wr_stall got %0d done=%b exp 3 done=1", st, ok); end
    vectors++; if (we_s !== 1'b1 || ma !== 32'h40 || md !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wr_req got we=%b addr=%h data=%h exp 1/40/deadbeef", we_s, ma, md); end
    xact(1'b1, 1'b0, 32'h40, 32'h0, 1, 32'h0, st, rd, en, we_s, ma, md, ok);
    vectors++; if (st !== 0 || rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wr_hit_read got st=%0d data=%h exp 0/deadbeef", st, rd); end
    vectors++; if (hit_count_o !== 32'd2 || miss_count_o !== 32'd1) begin miscompares++; $display("FAIL wr_cnt got %0d/%0d exp 2/1", hit_count_o, miss_count_o); end
  endtask

  task automatic test_write_miss();
    xact(1'b0, 1'b1, 32'h80, 32'hCAFE_F00D, 1, 32'h0, st, rd, en, we_s, ma, md, ok);
    vectors++; if (st !== 2 || en !== 1) begin miscompares++; $display("FAIL wm_stall got %0d/%0d exp 2/1", st, en); end
    vectors++; if (we_s !== 1'b1 || ma !== 32'h80 || md !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL wm_req got we=%b addr=%h data=%h exp 1/80/cafef00d", we_s, ma, md); end
    vectors++; if (miss_count_o !== 32'd1) begin miscompares++; $display("FAIL wm_cnt got %0d exp 1", miss_count_o); end
    xact(1'b1, 1'b0, 32'h80, 32'h0, 2, 32'h0000_0055, st, rd, en, we_s, ma, md, ok);
    vectors++; if (st !== 3 || we_s !== 1'b0 || ma !== 32'h80) begin miscompares++; $display("FAIL wm_noalloc got st=%0d we=%b addr=%h exp 3/0/80", st, we_s, ma); end
    vectors++; if (rd !== 32'h55 || miss_count_o !== 32'd2) begin miscompares++; $display("FAIL wm_fill got %h cnt=%0d exp 55 cnt=2", rd, miss_count_o); end
  endtask

  task automatic test_conflict();
    do_reset();
    xact(1'b1, 1'b0, 32'h00, 32'h0, 1, 32'hA0, st, rd, en, we_s, ma, md, ok);
    vectors++; if (st !== 2 || rd !== 32'hA0) begin miscompares++; $display("FAIL cf_first got st=%0d data=%h exp 2/a0", st, rd); end
    xact(1'b1, 1'b0, 32'h20, 32'h0, 1, 32'hA1, st, rd, en, we_s, ma, md, ok);
    vectors++; if (st !== 2 || rd !== 32'hA1) begin miscompares++; $display("FAIL cf_second got st=%0d data=%h exp 2/a1", st, rd); end
    xact(1'b1, 1'b0, 32'h00, 32'h0, 1, 32'hA2, st, rd, en, we_s, ma, md, ok);
    vectors++; if (st !== 2 || rd !== 32'hA2) begin miscompares++; $display("FAIL cf_third got st=%0d data=%h exp 2/a2", st, rd); end
    vectors++; if (miss_count_o !== 32'd3 || hit_count_o !== 32'd0) begin miscompares++; $display("FAIL cf_cnt got %0d/%0d exp 3/0", miss_count_o, hit_count_o); end
  endtask

  task automatic test_reset_mid();
    xact(1'b1, 1'b0, 32'h104, 32'h0, 1, 32'h11, st, rd, en, we_s, ma, md, ok);
    @(negedge clk_i);
    MemRead_i = 1'b1; Address_i = 32'h108;
    @(negedge clk_i);
    #1;
    vectors++; if (mem_enable_o !== 1'b1) begin miscompares++; $display("FAIL rm_enable got %b exp 1", mem_enable_o); end
    rst_n_i = 1'b0;
    #1;
    vectors++; if (mem_enable_o !== 1'b0) begin miscompares++; $display("FAIL rm_async_en got %b exp 0", mem_enable_o); end
    vectors++; if (ReadData_o !== 32'd0 || mem_addr_o !== 32'd0 || mem_data_o !== 32'd0 || mem_write_o !== 1'b0) begin miscompares++; $display("FAIL rm_outs got %h/%h/%h/%b exp 0", ReadData_o, mem_addr_o, mem_data_o, mem_write_o); end
    vectors++; if (hit_count_o !== 32'd0 || miss_count_o !== 32'd0) begin miscompares++; $display("FAIL rm_cnt got %0d/%0d exp 0/0", hit_count_o, miss_count_o); end
    MemRead_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    xact(1'b1, 1'b0, 32'h104, 32'h0, 1, 32'h22, st, rd, en, we_s, ma, md, ok);
    vectors++; if (st !== 2 || rd !== 32'h22 || miss_count_o !== 32'd1) begin miscompares++; $display("FAIL rm_remiss got st=%0d data=%h cnt=%0d exp 2/22/1", st, rd, miss_count_o); end
  endtask

  task automatic test_both_and_idle_ack();
    xact(1'b1, 1'b1, 32'h104, 32'h77, 1, 32'h0, st, rd, en, we_s, ma, md, ok);
    vectors++; if (we_s !== 1'b1 || md !== 32'h77 || st !== 2) begin miscompares++; $display("FAIL both_write got we=%b data=%h st=%0d exp 1/77/2", we_s, md, st); end
    vectors++; if (miss_count_o !== 32'd1 || hit_count_o !== 32'd0) begin miscompares++; $display("FAIL both_cnt got %0d/%0d exp 1/0", miss_count_o, hit_count_o); end
    xact(1'b1, 1'b0, 32'h104, 32'h0, 1, 32'h0, st, rd, en, we_s, ma, md, ok);
    vectors++; if (st !== 0 || rd !== 32'h77 || hit_count_o !== 32'd1) begin miscompares++; $display("FAIL both_hit got st=%0d data=%h hits=%0d exp 0/77/1", st, rd, hit_count_o); end
    @(negedge clk_i);
    mem_ack_i = 1'b1; mem_data_i = 32'h99;
    #1;
    vectors++; if (stall_o !== 1'b0 || mem_enable_o !== 1'b0) begin miscompares++; $display("FAIL idle_ack got stall=%b en=%b exp 0/0", stall_o, mem_enable_o); end
    @(negedge clk_i);
    mem_ack_i = 1'b0; mem_data_i = 32'h0;
    #1;
    vectors++; if (ReadData_o !== 32'h77 || mem_enable_o !== 1'b0 || stall_o !== 1'b0) begin miscompares++; $display("FAIL idle_ack_hold got data=%h en=%b stall=%b exp 77/0/0", ReadData_o, mem_enable_o, stall_o); end
    vectors++; if (hit_count_o !== 32'd1 || miss_count_o !== 32'd1) begin miscompares++; $display("FAIL idle_ack_cnt got %0d/%0d exp 1/1", hit_count_o, miss_count_o); end
    xact(1'b1, 1'b0, 32'h104, 32'h0, 1, 32'h0, st, rd, en, we_s, ma, md, ok);
    vectors++; if (st !== 0 || rd !== 32'h77) begin miscompares++; $display("FAIL idle_ack_line got st=%0d data=%h exp 0/77", st, rd); end
  endtask

  initial begin
    test_reset();
    test_read_miss_hit();
    test_write_hit();
    test_write_miss();
    test_conflict();
    test_reset_mid();
    test_both_and_idle_ack();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
endmodule
